vliw_fetch_unit: RTL
====================

VLIW_FETCH_UNIT -- requirements
Module: vliw_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width in packet units.
REQ-002 SHALL have parameter PKT_W, default 320, packet width (10 slots x 32 bits).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, packet-buffer entries (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-007 SHALL have port imem_req_ready, input, 1, instruction memory accepts the request.
REQ-008 SHALL have port imem_addr, output, PC_W, packet index requested.
REQ-009 SHALL have port imem_rsp_valid, input, 1, response data valid.
REQ-010 SHALL have port imem_rsp_data, input, PKT_W, returned packet.
REQ-011 SHALL have port redirect_valid, input, 1, one-cycle PC redirect strobe.
REQ-012 SHALL have port redirect_pc, input, PC_W, redirect target.
REQ-013 SHALL have port pkt_valid, output, 1, packet available to decode.
REQ-014 SHALL have port pkt_ready, input, 1, decode consumes the packet.
REQ-015 SHALL have port pkt_data, output, PKT_W, packet to decode.
REQ-016 SHALL have port pkt_pc, output, PC_W, packet index of pkt_data.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT and FLUSH, with at most one request outstanding.
REQ-018 SHALL move from IDLE to FETCH on the first cycle after reset release, with fetch_pc = 0.
REQ-019 In FETCH, SHALL assert imem_req_valid only when fifo_count + 1 <= FIFO_DEPTH (credit check), with imem_addr = fetch_pc.
REQ-020 On imem_req_valid && imem_req_ready, SHALL latch req_pc = fetch_pc, set fetch_pc = fetch_pc + 1 (wrapping from 2^PC_W-1 to 0), and enter WAIT.
REQ-021 In WAIT, on imem_rsp_valid, SHALL push {imem_rsp_data, req_pc} into the FIFO and return to FETCH.
REQ-022 SHALL drive pkt_valid high when the FIFO is non-empty, present the head entry on pkt_data and pkt_pc, and pop on pkt_valid && pkt_ready.
REQ-023 Push-to-pkt_valid latency SHALL be 1 cycle; reset-to-first-request latency SHALL be 1 cycle.
REQ-024 SHALL hold pkt_data and pkt_pc stable while pkt_valid && !pkt_ready.
REQ-025 On a simultaneous push and pop, SHALL leave fifo_count unchanged; a push to a full FIFO SHALL be impossible by the credit check.
REQ-026 On redirect_valid, SHALL empty the FIFO in the same edge and set fetch_pc = redirect_pc; a pkt_ready in that cycle SHALL be ignored.
REQ-027 On redirect_valid in WAIT without imem_rsp_valid, or in FETCH with a request accepted in the same cycle, SHALL enter FLUSH.
REQ-028 On redirect_valid with imem_rsp_valid in the same cycle, SHALL discard that response and go to FETCH.
REQ-029 In FLUSH, SHALL discard the next response and go to FETCH; another redirect in FLUSH SHALL only update fetch_pc.
REQ-030 In FETCH, a redirect with no accept SHALL change imem_addr to redirect_pc on the next cycle; this is the only permitted change of a pending request.

Reset
REQ-031 When rst_n = 0 at a clock edge: state = IDLE, fetch_pc = 0, req_pc = 0, FIFO empty.
REQ-032 When rst_n = 0 at a clock edge: imem_req_valid = 0, imem_addr = 0, pkt_valid = 0, pkt_data = 0, pkt_pc = 0.
REQ-033 A reset in WAIT or FLUSH SHALL abandon the outstanding request; the memory is reset in the same cycle.

Configuration
REQ-034 With FETCH_NOP_SQUASH_EN defined, a response whose imem_rsp_data is all-zero SHALL NOT be pushed; the FSM still returns to FETCH and fetch_pc still advances.
REQ-035 Without FETCH_NOP_SQUASH_EN, all-zero packets SHALL be delivered like any other packet.

Structure
REQ-036 Package vliw_pkg SHALL hold SLOT_CNT = 10, INST_W = 32, PKT_W, PC_W, the fetch_state_t enum, and the typedef of a FIFO entry {packet, pc}.
REQ-037 The FIFO SHALL be the sub-module fetch_fifo (parameterised depth and width, synchronous clear, count output).

Verification
REQ-038 Reset release, imem_req_ready = 1, 1-cycle response latency, pkt_ready = 1 -> pkt_pc sequence 0, 1, 2, 3 with matching pkt_data.
REQ-039 pkt_ready = 0 for 10 cycles -> exactly 4 packets buffered, imem_req_valid = 0, pkt_data stable; on release, pc 0..3 are delivered in order.
REQ-040 redirect_valid with redirect_pc = 0x40 while in WAIT -> the stale response is discarded and the next pkt_pc = 0x40.
REQ-041 fetch_pc preset to 0xFFFFFFFF via redirect -> delivered pkt_pc 0xFFFFFFFF then 0x00000000.
REQ-042 With FETCH_NOP_SQUASH_EN, a zero packet at pc 2 -> delivered pkt_pc 0, 1, 3; without the macro -> 0, 1, 2, 3.
REQ-043 rst_n = 0 in the middle of WAIT -> all outputs zero on the next edge; after release, the first request has addr 0.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW fetch path.
package vliw_pkg;

  localparam int unsigned SLOT_CNT = 10;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned PKT_W    = SLOT_CNT * INST_W;
  localparam int unsigned PC_W     = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StWait  = 2'd2,
    StFlush = 2'd3
  } fetch_state_t;

  // One packet-buffer entry: fetched packet plus the packet index it came from.
  typedef struct packed {
    logic [PKT_W-1:0] pkt;
    logic [PC_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Packet buffer for the fetch unit: power-of-two depth, synchronous clear,
// occupancy count, head entry forced to zero while empty.
module fetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 352
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic [Width-1:0]          push_data_i,
  input  logic                      pop_i,
  output logic [Width-1:0]          head_o,
  output logic                      empty_o,
  output logic [$clog2(Depth):0]    count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]    count_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(Depth));
  assign count_o = count_q;

  // Clear wins over push and pop in the same cycle.
  assign do_push = push_i && !full && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  // Pointers and occupancy; pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vliw_fetch_unit.sv
// VLIW instruction fetch unit: single-outstanding request FSM feeding a packet
// buffer, with PC redirect and flush of in-flight responses.
// Optional build macro FETCH_NOP_SQUASH_EN: drop all-zero packets instead of
// buffering them (the PC still advances).
module vliw_fetch_unit #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned PKT_W      = 320,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [PKT_W-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic [PKT_W-1:0] pkt_data,
  output logic [PC_W-1:0]  pkt_pc
);

  import vliw_pkg::*;

  localparam int unsigned EntryW = PKT_W + PC_W;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic              credit_ok, req_fire, keep_rsp, push, pop;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [EntryW-1:0] head;

  // Only request when the response is guaranteed a free buffer slot.
  assign credit_ok      = (32'(fifo_count) + 32'd1) <= FIFO_DEPTH;
  assign imem_req_valid = (state_q == StFetch) && credit_ok;
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef FETCH_NOP_SQUASH_EN
  assign keep_rsp = |imem_rsp_data;
`else
  assign keep_rsp = 1'b1;
`endif

  // A response arriving together with a redirect is stale and dropped.
  assign push = (state_q == StWait) && imem_rsp_valid && !redirect_valid && keep_rsp;
  assign pop  = pkt_valid && pkt_ready;

  // Next-state logic for the request FSM and the fetch/request PCs.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (req_fire) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_W'(1);
          state_d    = redirect_valid ? StFlush : StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          state_d = StFetch;
        end else if (redirect_valid) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (imem_rsp_valid) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
    // Redirect target overrides the sequential increment.
    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(EntryW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (redirect_valid),
    .push_i     (push),
    .push_data_i({imem_rsp_data, req_pc_q}),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign pkt_valid          = !fifo_empty;
  assign {pkt_data, pkt_pc} = head;

endmodule
